// File: rtl/add_sub_serial.sv
// -----------------------------------------------------------------------------
// add_sub_serial
//
// Digit-serial two's-complement adder/subtractor. Operands are accepted via a
// valid/ready handshake, then processed DIGIT bits per clock, LSB first. The
// result and flags are held under an output valid/ready handshake.
// Subtraction is a + ~b + 1: the inverted B is latched and the carry register
// is preloaded with the mode bit.
//
// Parameters:
//   WIDTH : operand/result width in bits (>= 2)
//   DIGIT : bits processed per RUN cycle, must divide WIDTH
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : operands and mode valid
//   in_ready  : block can accept operands (IDLE only)
//   a, b      : operands
//   m         : mode, 0 = a+b, 1 = a-b
//   out_valid : result valid (DONE only)
//   out_ready : consumer takes result
//   sum       : result, modulo 2^WIDTH
//   cout      : carry out of MSB (subtract: 1 = no borrow)
//   ovf       : signed overflow
//
// Build option:
//   ADD_SUB_SERIAL_SATURATE_EN : when defined, an overflowing sum is clamped
//   to the most positive/negative value according to the sign of a. cout and
//   ovf always report the unclamped arithmetic.
// -----------------------------------------------------------------------------
module add_sub_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             m,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   generate
      if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
         $error("add_sub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q,     state_d;
   logic [WIDTH-1:0] a_q,         a_d;
   logic [WIDTH-1:0] b_q,         b_d;
   logic             carry_q,     carry_d;
   logic [CW-1:0]    cnt_q,       cnt_d;
   logic [WIDTH-1:0] res_q,       res_d;
   logic [WIDTH-1:0] sum_q,       sum_d;
   logic             cout_q,      cout_d;
   logic             ovf_q,       ovf_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [DIGIT-1:0] a_sl_s;
   logic [DIGIT-1:0] b_sl_s;
   logic [DIGIT:0]   slice_s;
   logic [WIDTH-1:0] res_ins_s;
   logic             cin_msb_s;
   logic             ovf_s;
   logic [WIDTH-1:0] final_sum_s;

   // Slice adder: current digit of both operands plus the running carry.
   always_comb begin
      a_sl_s    = a_q[cnt_q*DIGIT +: DIGIT];
      b_sl_s    = b_q[cnt_q*DIGIT +: DIGIT];
      slice_s   = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{DIGIT{1'b0}}, carry_q};
      res_ins_s = res_q;
      res_ins_s[cnt_q*DIGIT +: DIGIT] = slice_s[DIGIT-1:0];
      // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
      cin_msb_s = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ res_ins_s[WIDTH-1];
      ovf_s     = cin_msb_s ^ slice_s[DIGIT];
   end

   // Final sum selection, optionally clamped on signed overflow.
   always_comb begin
`ifdef ADD_SUB_SERIAL_SATURATE_EN
      if (ovf_s) begin
         if (a_q[WIDTH-1]) begin
            final_sum_s = {1'b1, {(WIDTH-1){1'b0}}};
         end else begin
            final_sum_s = {1'b0, {(WIDTH-1){1'b1}}};
         end
      end else begin
         final_sum_s = res_ins_s;
      end
`else
      final_sum_s = res_ins_s;
`endif
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      res_d       = res_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d        = a;
               b_d        = b ^ {WIDTH{m}};
               carry_d    = m;
               cnt_d      = {CW{1'b0}};
               in_ready_d = 1'b0;
               state_d    = ST_RUN;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_RUN: begin
            res_d   = res_ins_s;
            carry_d = slice_s[DIGIT];
            if (cnt_q == LAST_CNT) begin
               cnt_d       = {CW{1'b0}};
               sum_d       = final_sum_s;
               cout_d      = slice_s[DIGIT];
               ovf_d       = ovf_s;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               cnt_d       = cnt_q + CW'(1);
               state_d     = ST_RUN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_DONE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= {WIDTH{1'b0}};
         b_q         <= {WIDTH{1'b0}};
         carry_q     <= 1'b0;
         cnt_q       <= {CW{1'b0}};
         res_q       <= {WIDTH{1'b0}};
         sum_q       <= {WIDTH{1'b0}};
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         res_q       <= res_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// -----------------------------------------------------------------------------
// tb_add_sub_serial
//
// Four DUT lanes: lane 0 is WIDTH=16/DIGIT=4, lanes 1..3 are WIDTH=8 with
// DIGIT=1, 2 and 8. A driver issues operations one lane at a time and pushes
// the reference result into a scoreboard queue; an independent monitor checks
// every presented result, latency, hold behaviour and reset values.
// Honours ADD_SUB_SERIAL_SATURATE_EN in the reference model.
// -----------------------------------------------------------------------------
module tb_add_sub_serial;

   typedef struct {
      int          lane;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      int          acc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [3:0]  m;
   logic [3:0]  cout;
   logic [3:0]  ovf;
   logic [15:0] a_w   [4];
   logic [15:0] b_w   [4];
   logic [15:0] sum_w [4];

   exp_t        q[$];
   int          cyc    = 0;
   int          n_vec  = 0;
   int          n_miss = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to time-stamp accept edges.
   always @(posedge clk) cyc <= cyc + 1;

   add_sub_serial #(.WIDTH(16), .DIGIT(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a_w[0]), .b(b_w[0]), .m(m[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .sum(sum_w[0]), .cout(cout[0]), .ovf(ovf[0])
   );

   for (genvar k = 1; k < 4; k++) begin : g_lane
      localparam int DG = (k == 1) ? 1 : ((k == 2) ? 2 : 8);
      logic [7:0] s8;
      add_sub_serial #(.WIDTH(8), .DIGIT(DG)) u_dut (
         .clk(clk), .rst_n(rst_n), .in_valid(in_valid[k]), .in_ready(in_ready[k]),
         .a(a_w[k][7:0]), .b(b_w[k][7:0]), .m(m[k]), .out_valid(out_valid[k]),
         .out_ready(out_ready[k]), .sum(s8), .cout(cout[k]), .ovf(ovf[k])
      );
      assign sum_w[k] = {8'h00, s8};
   end

   function automatic int lane_n(int k);
      case (k)
         0:       return 4;
         1:       return 8;
         2:       return 4;
         default: return 1;
      endcase
   endfunction

   // Reference: plain integer arithmetic on the operand values.
   function automatic exp_t model(int k, logic [15:0] av, logic [15:0] bv, logic mv);
      exp_t   r;
      int     w;
      longint md, ua, ub, sa, sb, full, sr;
      w  = (k == 0) ? 16 : 8;
      md = longint'(1) << w;
      ua = longint'(av);
      ub = longint'(bv);
      sa = av[w-1] ? ua - md : ua;
      sb = bv[w-1] ? ub - md : ub;
      if (mv) begin
         full = ua + (md - 1 - ub) + 1;
         sr   = sa - sb;
      end else begin
         full = ua + ub;
         sr   = sa + sb;
      end
      r.lane = k;
      r.acc  = 0;
      r.sum  = 16'(full % md);
      r.cout = (full >= md);
      r.ovf  = (sr >= md / 2) || (sr < -(md / 2));
`ifdef ADD_SUB_SERIAL_SATURATE_EN
      if (r.ovf) r.sum = (sa < 0) ? 16'(md / 2) : 16'(md / 2 - 1);
`endif
      return r;
   endfunction

   task automatic cmp(string nm, int k, logic [15:0] act, logic [15:0] exv);
      n_vec++;
      if (act !== exv) begin
         n_miss++;
         $display("FAIL %s lane%0d t=%0t: got %h expected %h", nm, k, $time, act, exv);
      end
   endtask

   // Monitor: checks outputs on every falling edge and on reset assertion.
   initial begin : monitor
      logic [15:0] last_sum  [4];
      logic        last_cout [4];
      logic        last_ovf  [4];
      bit          prev_ov   [4];
      bit          hs        [4];
      bit          in_rst;
      exp_t        e;
      in_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         last_sum[k] = 16'h0000; last_cout[k] = 1'b0; last_ovf[k] = 1'b0;
         prev_ov[k] = 1'b0; hs[k] = 1'b0;
      end
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            if (!in_rst) begin
               in_rst = 1'b1;
               #1;
               for (int k = 0; k < 4; k++) begin
                  cmp("rst_in_ready",  k, 16'(in_ready[k]),  16'h0001);
                  cmp("rst_out_valid", k, 16'(out_valid[k]), 16'h0000);
                  cmp("rst_sum",       k, sum_w[k],          16'h0000);
                  cmp("rst_cout",      k, 16'(cout[k]),      16'h0000);
                  cmp("rst_ovf",       k, 16'(ovf[k]),       16'h0000);
                  last_sum[k] = 16'h0000; last_cout[k] = 1'b0; last_ovf[k] = 1'b0;
                  prev_ov[k] = 1'b0; hs[k] = 1'b0;
               end
               q.delete();
            end
         end else begin
            in_rst = 1'b0;
            for (int k = 0; k < 4; k++) begin
               if (hs[k]) begin
                  cmp("in_ready_after_take", k, 16'(in_ready[k]), 16'h0001);
                  hs[k] = 1'b0;
               end
               if (out_valid[k]) begin
                  if ((q.size() == 0) || (q[0].lane != k)) begin
                     n_vec++;
                     n_miss++;
                     $display("FAIL unexpected_out_valid lane%0d t=%0t: got sum %h with no pending operation",
                              k, $time, sum_w[k]);
                  end else begin
                     e = q[0];
                     cmp("sum",      k, sum_w[k],          e.sum);
                     cmp("cout",     k, 16'(cout[k]),      16'(e.cout));
                     cmp("ovf",      k, 16'(ovf[k]),       16'(e.ovf));
                     cmp("in_ready_done", k, 16'(in_ready[k]), 16'h0000);
                     if (!prev_ov[k]) cmp("latency", k, 16'(cyc - e.acc), 16'(lane_n(k)));
                     if (out_ready[k]) begin
                        void'(q.pop_front());
                        last_sum[k] = e.sum; last_cout[k] = e.cout; last_ovf[k] = e.ovf;
                        hs[k] = 1'b1;
                     end
                  end
               end else begin
                  cmp("sum_hold",  k, sum_w[k],     last_sum[k]);
                  cmp("cout_hold", k, 16'(cout[k]), 16'(last_cout[k]));
                  cmp("ovf_hold",  k, 16'(ovf[k]),  16'(last_ovf[k]));
               end
               prev_ov[k] = out_valid[k];
            end
         end
      end
   end

   task automatic issue(int k, logic [15:0] av, logic [15:0] bv, logic mv);
      exp_t e;
      bit   got;
      a_w[k] = av; b_w[k] = bv; m[k] = mv; in_valid[k] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = in_ready[k];
      end
      if (!got) begin
         $display("FAIL accept_timeout lane%0d: in_ready stayed 0, required 1", k);
         $fatal(1, "accept timeout");
      end
      @(posedge clk);
      #1;
      e     = model(k, av, bv, mv);
      e.acc = cyc;
      q.push_back(e);
      in_valid[k] = 1'b0;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
         $fatal(1, "drain timeout");
      end
      @(posedge clk);
      #1;
   endtask

   // Driver: directed cases, back-pressure, reset abort, random sweeps.
   initial begin : driver
      logic [15:0] msk;
      rst_n     = 1'b1;
      in_valid  = 4'h0;
      out_ready = 4'hF;
      m         = 4'h0;
      for (int k = 0; k < 4; k++) begin
         a_w[k] = 16'h0000; b_w[k] = 16'h0000;
      end
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(0, 16'h0007, 16'h0001, 1'b1);
      issue(0, 16'hFFFF, 16'h0001, 1'b0);
      issue(0, 16'h0002, 16'h0008, 1'b1);
      issue(0, 16'h7FFF, 16'h0001, 1'b0);
      issue(0, 16'h8000, 16'h0001, 1'b1);
      issue(0, 16'h8000, 16'h8000, 1'b0);
      issue(0, 16'h0000, 16'h0000, 1'b1);
      wait_empty();

      // Back-pressure with new operands waiting on the input.
      out_ready[0] = 1'b0;
      issue(0, 16'h1234, 16'h1111, 1'b0);
      a_w[0] = 16'hBEEF; b_w[0] = 16'h0F0F; m[0] = 1'b1; in_valid[0] = 1'b1;
      for (int i = 0; i < 50 && !out_valid[0]; i++) @(negedge clk);
      if (!out_valid[0]) begin
         $display("FAIL out_valid_timeout lane0: out_valid stayed 0, required 1");
         $fatal(1, "out_valid timeout");
      end
      repeat (3) @(posedge clk);
      #1 out_ready[0] = 1'b1;
      issue(0, 16'hBEEF, 16'h0F0F, 1'b1);
      wait_empty();

      // Reset during the second RUN cycle aborts the operation.
      issue(0, 16'h1111, 16'h2222, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #10 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      issue(0, 16'h0003, 16'h0004, 1'b0);
      wait_empty();

      for (int i = 0; i < 100; i++) begin
         issue(0, 16'($urandom), 16'($urandom), 1'($urandom));
      end
      wait_empty();

      for (int k = 1; k < 4; k++) begin
         msk = 16'h00FF;
         for (int i = 0; i < 200; i++) begin
            issue(k, 16'($urandom) & msk, 16'($urandom) & msk, 1'($urandom));
         end
         wait_empty();
      end

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
